if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: instruction word presented on id_inst when no valid instruction is held.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 rst  in  1: reset, synchronous and active-high.
REQ-005 npc  in  32: next PC from the PC-select stage, which returns pc+4 or the jump target.
REQ-006 stall  in  1: ID-stage hazard hold.
REQ-007 flush  in  1: control transfer taken; squash the in-flight fetch and the IF/ID contents.
REQ-008 pc  out  32: current fetch PC, fed back to the PC-select stage.
REQ-009 imem_req  out  1: fetch request.
REQ-010 imem_addr  out  32: fetch address; always equal to pc.
REQ-011 imem_ready  in  1: imem_rdata is valid this cycle.
REQ-012 imem_rdata  in  32: fetched instruction word.
REQ-013 id_pc  out  32: PC of the instruction held in IF/ID.
REQ-014 id_inst  out  32: instruction held in IF/ID.
REQ-015 id_valid  out  1: IF/ID holds a real instruction.

Function
REQ-016 The block shall have two states: FETCH (request outstanding) and BUF (word captured while stalled).
REQ-017 imem_req shall be 1 exactly when the state is FETCH and rst=0.
REQ-018 pc[1:0] shall always be 2'b00, with npc[1:0] ignored on every load.
REQ-019 In FETCH with imem_ready=1, stall=0 and flush=0, the block shall:
  - load IF/ID with {pc, imem_rdata, valid=1};
  - set pc<=npc;
  - stay in FETCH.
  This gives 1-cycle issue-to-ID latency when memory is zero-wait.
REQ-020 In FETCH with imem_ready=0, stall=0 and flush=0, the block shall:
  - set id_valid<=0 and id_inst<=NOP_INST, a bubble;
  - hold pc.
REQ-021 In FETCH with imem_ready=1, stall=1 and flush=0, the block shall:
  - capture {pc, imem_rdata} into a one-entry buffer;
  - hold IF/ID;
  - set pc<=npc;
  - go to BUF.
REQ-022 In FETCH with imem_ready=0, stall=1 and flush=0, the block shall hold IF/ID and pc.
REQ-023 In BUF with stall=1 and flush=0, the block shall hold all state and keep imem_req=0.
REQ-024 In BUF with stall=0 and flush=0, the block shall:
  - move the buffer into IF/ID with valid=1;
  - go to FETCH, with pc unchanged since it already holds the next address.
REQ-025 flush=1 shall override stall and imem_ready in either state, and the block shall:
  - set id_valid<=0 and id_inst<=NOP_INST;
  - discard the buffer and any imem_rdata returned that cycle;
  - set pc<=npc, the jump target;
  - go to FETCH.
REQ-026 While stall=1 and flush=0, id_pc, id_inst and id_valid shall not change.
REQ-027 PC arithmetic shall be 32-bit and wrap modulo 2^32, so 32'hFFFF_FFFC followed by pc+4 gives 32'h0000_0000.
REQ-028 All outputs shall be registered except imem_req and imem_addr, which are derived from state and pc.

Reset
REQ-029 While rst=1 at a clock edge, the block shall set:
  - pc<=RESET_PC;
  - state<=FETCH;
  - id_valid<=0, id_pc<=0, id_inst<=NOP_INST;
  - buffer cleared.
REQ-030 rst shall take priority over flush, stall and imem_ready.
REQ-031 A fetch outstanding when rst asserts shall be dropped, and no IF/ID load shall occur from it.

Verification
REQ-032 Reset: hold rst 2 cycles -> pc=0, id_valid=0, id_inst=32'h13, imem_req=0; release -> imem_req=1, imem_addr=0.
REQ-033 Streaming: imem_ready=1 every cycle, npc=pc+4, words 0xA0..0xA3 -> id_pc=0,4,8,C with id_inst=0xA0..0xA3 on consecutive cycles, id_valid=1.
REQ-034 Wait states: imem_ready low for 2 cycles at pc=8 -> 2 bubbles (id_valid=0), pc stays 8, then id_pc=8.
REQ-035 Stall with return: stall=1 while word 0xB4 at pc=4 returns -> IF/ID unchanged, state BUF, imem_req=0, pc=8; stall released -> id_pc=4, id_inst=0xB4, fetch resumes at 8.
REQ-036 Flush overrides stall: in BUF with stall=1, flush=1, npc=0x100 -> next cycle id_valid=0, buffered word lost, pc=0x100, imem_req=1.
REQ-037 Wrap: pc=32'hFFFF_FFFC with npc=pc+4 -> pc=0 after fetch; npc=32'h0000_0103 on flush -> pc=32'h0000_0100.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register and one-entry stall buffer
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  // FETCH: a request is outstanding at pc. BUF: a word arrived during a stall
  // and is parked until ID can accept it; no request is issued meanwhile.
  typedef enum logic {FETCH = 1'b0, BUF = 1'b1} state_t;

  state_t      state;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic [31:0] npc_aligned;

  // Fetch addresses are word aligned; the low bits of npc are dropped on every load.
  assign npc_aligned = {npc[31:2], 2'b00};

  // Request and address come straight from state and pc so memory sees them in the same cycle.
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;

  // Fetch control, IF/ID register and stall buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_inst  <= NOP_INST;
      buf_pc   <= 32'h0;
      buf_inst <= 32'h0;
    end else if (flush) begin
      // Control transfer: squash IF/ID, drop the buffer and any returning word.
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
      buf_pc   <= 32'h0;
      buf_inst <= 32'h0;
      pc       <= npc_aligned;
      state    <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= npc_aligned;
            if (stall) begin
              // ID cannot take the word yet; park it and stop fetching.
              buf_pc   <= pc;
              buf_inst <= imem_rdata;
              state    <= BUF;
            end else begin
              id_pc    <= pc;
              id_inst  <= imem_rdata;
              id_valid <= 1'b1;
            end
          end else if (!stall) begin
            // Memory wait state: hand ID a bubble and keep requesting the same pc.
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
          end
        end
        BUF: begin
          if (!stall) begin
            // pc already points past the buffered word, so fetch resumes there.
            id_pc    <= buf_pc;
            id_inst  <= buf_inst;
            id_valid <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized and directed self-checking bench for if_stage
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int tests_run = 0;
  int tests_failed = 0;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .stall      (stall),
    .flush      (flush),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of words that arrived but could not enter ID.
  typedef struct {
    logic [31:0] wpc;
    logic [31:0] winst;
  } word_t;

  word_t       parked[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_id_pc = 32'h0;
  logic [31:0] m_id_inst = NOP;
  logic        m_id_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic f, input logic rd,
                            input logic [31:0] data, input logic [31:0] nxt);
    word_t w;
    if (r) begin
      m_pc = 32'h0;
      parked.delete();
      m_id_valid = 1'b0;
      m_id_pc = 32'h0;
      m_id_inst = NOP;
    end else if (f) begin
      parked.delete();
      m_pc = nxt & ~32'd3;
      m_id_valid = 1'b0;
      m_id_inst = NOP;
    end else if (parked.size() > 0) begin
      if (!s) begin
        w = parked.pop_front();
        m_id_pc = w.wpc;
        m_id_inst = w.winst;
        m_id_valid = 1'b1;
      end
    end else if (rd) begin
      if (s) begin
        w.wpc = m_pc;
        w.winst = data;
        parked.push_back(w);
      end else begin
        m_id_pc = m_pc;
        m_id_inst = data;
        m_id_valid = 1'b1;
      end
      m_pc = nxt & ~32'd3;
    end else if (!s) begin
      m_id_valid = 1'b0;
      m_id_inst = NOP;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] data, input logic [31:0] nxt);
    rst = r; stall = s; flush = f; imem_ready = rd; imem_rdata = data; npc = nxt;
    model_step(r, s, f, rd, data, nxt);
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", {31'h0, imem_req}, {31'h0, (!r && parked.size() == 0)});
    check("id_valid", {31'h0, id_valid}, {31'h0, m_id_valid});
    check("id_inst", id_inst, m_id_inst);
    check("id_pc", id_pc, m_id_pc);
  endtask

  initial begin
    // Reset held two cycles.
    step(1, 0, 0, 0, 32'h0, 32'h0);
    step(1, 1, 1, 1, 32'hDEAD_BEEF, 32'h40);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_inst", id_inst, 32'h13);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    check("rel_req", {31'h0, imem_req}, 32'h1);
    check("rel_addr", imem_addr, 32'h0);

    // Zero-wait streaming.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 32'hA0 + i, m_pc + 32'd4);
      check("stream_pc", id_pc, 32'(i * 4));
      check("stream_inst", id_inst, 32'hA0 + i);
      check("stream_valid", {31'h0, id_valid}, 32'h1);
    end

    // Two wait states at pc=8.
    step(0, 0, 1, 1, 32'h0, 32'h8);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 32'h0, 32'h0);
      check("wait_bubble", {31'h0, id_valid}, 32'h0);
      check("wait_pc", pc, 32'h8);
    end
    step(0, 0, 0, 1, 32'hC8, 32'hC);
    check("wait_id_pc", id_pc, 32'h8);

    // Stall while word 0xB4 returns at pc=4, then release.
    step(0, 0, 1, 0, 32'h0, 32'h4);
    step(0, 1, 0, 1, 32'hB4, 32'h8);
    check("stall_req", {31'h0, imem_req}, 32'h0);
    check("stall_pc", pc, 32'h8);
    check("stall_hold", {31'h0, id_valid}, 32'h0);
    step(0, 1, 0, 1, 32'hEE, 32'h77);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    check("unstall_id_pc", id_pc, 32'h4);
    check("unstall_inst", id_inst, 32'hB4);
    check("unstall_req", {31'h0, imem_req}, 32'h1);
    check("unstall_addr", imem_addr, 32'h8);

    // Flush overrides stall while a word is parked.
    step(0, 0, 1, 0, 32'h0, 32'h4);
    step(0, 1, 0, 1, 32'hB4, 32'h8);
    step(0, 1, 1, 1, 32'h55, 32'h100);
    check("flush_valid", {31'h0, id_valid}, 32'h0);
    check("flush_pc", pc, 32'h100);
    check("flush_req", {31'h0, imem_req}, 32'h1);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    check("flush_lost", {31'h0, id_valid}, 32'h0);

    // Wrap at the top of the address space and low-bit masking on flush.
    step(0, 0, 1, 0, 32'h0, 32'hFFFF_FFFF);
    check("wrap_top", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 32'h1234, m_pc + 32'd4);
    check("wrap_pc", pc, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 32'h0, 32'h0000_0103);
    check("mask_pc", pc, 32'h100);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic r, s, f, rd;
      logic [31:0] nxt;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 2) == 0);
      f  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 1) == 0);
      nxt = ($urandom_range(0, 3) != 0) ? m_pc + 32'd4 : $urandom;
      step(r, s, f, rd, $urandom, nxt);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
